// File: rtl/reset_sequencer.sv
// Staged system reset generator: asynchronous assertion, synchronous release after a lock-qualified
// hold time, then peripherals released first and the core a fixed stagger later.
module reset_sequencer #(
   parameter int unsigned             pTimerWidth = 19,
   parameter logic [pTimerWidth-1:0]  pHoldCycles = 19'd500_000,
   parameter logic [pTimerWidth-1:0]  pStagger    = 19'd16,
   parameter int unsigned             pSyncStages = 2
) (
   input  logic gClock,
   input  logic gResetN,
   input  logic iPllLocked,
   input  logic iSoftReset,
   output logic oPeriphResetN,
   output logic oCoreResetN,
   output logic oResetDone,
   output logic oBusy
);

   typedef enum logic [1:0] {
      S_WAIT_LOCK,
      S_HOLD,
      S_STAGGER,
      S_RUN
   } state_t;

   state_t                 state, state_nxt;
   logic [pTimerWidth-1:0] timer, timer_nxt;
   logic                   periph_nxt, core_nxt, done_nxt;
   logic                   rst_sync;
   logic [pSyncStages-1:0] lock_sync;
   logic                   locked;
   logic                   abort;

   // The lock chain only starts shifting one edge after gResetN releases, so the
   // release itself is synchronous and the lock is always seen through a full chain.
   always_ff @(posedge gClock or negedge gResetN) begin
      if (!gResetN) begin
         rst_sync  <= 1'b0;
         lock_sync <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         rst_sync <= 1'b1;
         if (rst_sync)
            lock_sync <= {lock_sync[pSyncStages-2:0], iPllLocked};
      end
   end

   assign locked = lock_sync[pSyncStages-1];
   assign abort  = iSoftReset || !locked;

   always_ff @(posedge gClock or negedge gResetN) begin
      if (!gResetN) begin
         state         <= S_WAIT_LOCK;
         timer         <= pHoldCycles;
         oPeriphResetN <= 1'b0;
         oCoreResetN   <= 1'b0;
         oResetDone    <= 1'b0;
         oBusy         <= 1'b1;
      end else begin
         state         <= state_nxt;
         timer         <= timer_nxt;
         oPeriphResetN <= periph_nxt;
         oCoreResetN   <= core_nxt;
         oResetDone    <= done_nxt;
         oBusy         <= (state_nxt != S_RUN);
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no latch is inferred.
      state_nxt  = state;
      timer_nxt  = timer;
      periph_nxt = oPeriphResetN;
      core_nxt   = oCoreResetN;
      done_nxt   = 1'b0;

      // Abort wins over a same-cycle timer expiry, so no stray done pulse escapes.
      if (state != S_WAIT_LOCK && abort) begin
         state_nxt  = S_WAIT_LOCK;
         timer_nxt  = pHoldCycles;
         periph_nxt = 1'b0;
         core_nxt   = 1'b0;
      end else begin
         unique case (state)
            S_WAIT_LOCK: begin
               timer_nxt  = pHoldCycles;
               periph_nxt = 1'b0;
               core_nxt   = 1'b0;
               if (locked)
                  state_nxt = S_HOLD;
            end
            S_HOLD: begin
               if (timer == '0) begin
                  state_nxt  = S_STAGGER;
                  timer_nxt  = pStagger;
                  periph_nxt = 1'b1;
               end else begin
                  timer_nxt = timer - pTimerWidth'(1);
               end
            end
            S_STAGGER: begin
               if (timer == '0) begin
                  state_nxt = S_RUN;
                  core_nxt  = 1'b1;
                  done_nxt  = 1'b1;
               end else begin
                  timer_nxt = timer - pTimerWidth'(1);
               end
            end
            S_RUN: begin
            end
         endcase
      end
   end

endmodule
